// File: rtl/spi_addr_sequencer.sv
// SPI address sequencer.
// Collects an MSB-first address header from the SPI byte stream, then steers
// RAM read prefetches or write strobes at an auto-incrementing address until
// the frame ends. The top header bit selects read (1) or write (0).
module spi_addr_sequencer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_BYTES = 2,
    parameter int ADDR_W     = 15,
    parameter int WRAP_W     = 0,
    parameter int CNT_W      = 16
) (
    input  logic              SPI_CLK,
    input  logic              RST,
    input  logic              start_of_transfer,
    input  logic              end_of_transfer,
    input  logic [DATA_W-1:0] data_in_value,
    input  logic              data_in_ready,
    input  logic              data_out_request,
    input  logic              write_enable_mask,
    output logic [ADDR_W-1:0] ram_address_out,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read_strobe,
    output logic              ram_write_strobe,
    output logic              address_strobe,
    output logic              header_error,
    output logic [CNT_W-1:0]  byte_count
);

    localparam int HDR_W = ADDR_BYTES * DATA_W;
    localparam int IDX_W = $clog2(ADDR_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDR_BYTES - 1);

    // Bits that take part in the increment; the rest of the address is held.
    // A wrap width of zero (or the full address width) means plain linear.
    localparam logic [ADDR_W-1:0] WRAP_MASK =
        (WRAP_W == 0 || WRAP_W >= ADDR_W) ? {ADDR_W{1'b1}}
                                          : ADDR_W'((1 << WRAP_W) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        RD,
        WR
    } state_t;

    state_t                  state_q, state_d;
    logic [HDR_W-DATA_W-1:0] hdr_q, hdr_d;
    logic [IDX_W-1:0]        hdrIdx_q, hdrIdx_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rdStb_q, rdStb_d;
    logic                    wrStb_q, wrStb_d;
    logic                    addrStb_q, addrStb_d;
    logic                    hdrErr_q, hdrErr_d;
    logic                    prefetch_q, prefetch_d;
    logic                    wrAdvance_q, wrAdvance_d;
    logic [HDR_W-1:0]        hdrShift;

    // Header register with the current byte shifted in at the bottom.
    assign hdrShift = {hdr_q, data_in_value};

    function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] inc;
        inc = a + ADDR_W'(1);
        return (a & ~WRAP_MASK) | (inc & WRAP_MASK);
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // State and datapath registers, cleared synchronously on RST.
    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            hdrIdx_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rdStb_q     <= 1'b0;
            wrStb_q     <= 1'b0;
            addrStb_q   <= 1'b0;
            hdrErr_q    <= 1'b0;
            prefetch_q  <= 1'b0;
            wrAdvance_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            hdrIdx_q    <= hdrIdx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdStb_q     <= rdStb_d;
            wrStb_q     <= wrStb_d;
            addrStb_q   <= addrStb_d;
            hdrErr_q    <= hdrErr_d;
            prefetch_q  <= prefetch_d;
            wrAdvance_q <= wrAdvance_d;
        end
    end

    // Next-state logic: a start pulse always wins and restarts the header;
    // strobes are one-cycle pulses so they default low every cycle.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        hdrIdx_d    = hdrIdx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdStb_d     = 1'b0;
        wrStb_d     = 1'b0;
        addrStb_d   = 1'b0;
        hdrErr_d    = 1'b0;
        prefetch_d  = 1'b0;
        wrAdvance_d = 1'b0;

        if (start_of_transfer) begin
            state_d  = HDR;
            hdr_d    = '0;
            hdrIdx_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                HDR: begin
                    if (end_of_transfer) begin
                        state_d  = IDLE;
                        hdrErr_d = 1'b1;
                    end else if (data_in_ready) begin
                        hdr_d = hdrShift[HDR_W-DATA_W-1:0];
                        if (hdrIdx_q == LAST_IDX) begin
                            hdrIdx_d   = '0;
                            addr_d     = hdrShift[ADDR_W-1:0];
                            addrStb_d  = 1'b1;
                            prefetch_d = hdrShift[HDR_W-1];
                            state_d    = hdrShift[HDR_W-1] ? RD : WR;
                        end else begin
                            hdrIdx_d = hdrIdx_q + IDX_W'(1);
                        end
                    end
                end
                RD: begin
                    if (end_of_transfer) begin
                        state_d = IDLE;
                    end else if (data_out_request) begin
                        addr_d  = nextAddr(addr_q);
                        rdStb_d = 1'b1;
                        cnt_d   = satInc(cnt_q);
                    end else if (prefetch_q) begin
                        rdStb_d = 1'b1;
                    end
                end
                WR: begin
                    // The address of a written byte is held through its
                    // strobe cycle and moves on at the edge that ends it.
                    if (wrAdvance_q) begin
                        addr_d = nextAddr(addr_q);
                    end
                    if (data_in_ready) begin
                        wdata_d     = data_in_value;
                        wrStb_d     = write_enable_mask;
                        wrAdvance_d = 1'b1;
                        cnt_d       = satInc(cnt_q);
                    end
                    if (end_of_transfer) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ram_address_out  = addr_q;
    assign ram_wdata        = wdata_q;
    assign ram_read_strobe  = rdStb_q;
    assign ram_write_strobe = wrStb_q;
    assign address_strobe   = addrStb_q;
    assign header_error     = hdrErr_q;
    assign byte_count       = cnt_q;

endmodule

// File: tb/tb_spi_addr_sequencer.sv
// Scoreboard bench for spi_addr_sequencer: three instances (defaults,
// 2-bit wrap with a 3-bit counter, 3-byte header) driven one at a time.
module tb_spi_addr_sequencer;

    typedef struct {
        int id;
        int kind;
        int addr;
        int data;
    } expEvent_t;

    logic SPI_CLK;
    logic RST;

    logic [2:0] sot, eot, dir, dor, msk;
    logic [7:0] din [0:2];

    logic [14:0] addr0, addr1;
    logic [19:0] addr2;
    logic [7:0]  wd0, wd1, wd2;
    logic [15:0] cnt0, cnt2;
    logic [2:0]  cnt1;
    logic [2:0]  rdS, wrS, aStb, hErr;

    expEvent_t  expq[$];
    logic [7:0] dataQ[$];
    bit         maskQ[$];

    int total;
    int bad;

    int abytes [0:2] = '{2, 2, 3};
    int aw     [0:2] = '{15, 15, 20};
    int ww     [0:2] = '{0, 2, 0};
    int cntMax [0:2] = '{65535, 7, 65535};
    string kindName [0:3] = '{"addr_strobe", "read", "write", "header_error"};

    spi_addr_sequencer dut0 (
        .SPI_CLK(SPI_CLK), .RST(RST),
        .start_of_transfer(sot[0]), .end_of_transfer(eot[0]),
        .data_in_value(din[0]), .data_in_ready(dir[0]),
        .data_out_request(dor[0]), .write_enable_mask(msk[0]),
        .ram_address_out(addr0), .ram_wdata(wd0),
        .ram_read_strobe(rdS[0]), .ram_write_strobe(wrS[0]),
        .address_strobe(aStb[0]), .header_error(hErr[0]),
        .byte_count(cnt0)
    );

    spi_addr_sequencer #(.WRAP_W(2), .CNT_W(3)) dut1 (
        .SPI_CLK(SPI_CLK), .RST(RST),
        .start_of_transfer(sot[1]), .end_of_transfer(eot[1]),
        .data_in_value(din[1]), .data_in_ready(dir[1]),
        .data_out_request(dor[1]), .write_enable_mask(msk[1]),
        .ram_address_out(addr1), .ram_wdata(wd1),
        .ram_read_strobe(rdS[1]), .ram_write_strobe(wrS[1]),
        .address_strobe(aStb[1]), .header_error(hErr[1]),
        .byte_count(cnt1)
    );

    spi_addr_sequencer #(.ADDR_BYTES(3), .ADDR_W(20)) dut2 (
        .SPI_CLK(SPI_CLK), .RST(RST),
        .start_of_transfer(sot[2]), .end_of_transfer(eot[2]),
        .data_in_value(din[2]), .data_in_ready(dir[2]),
        .data_out_request(dor[2]), .write_enable_mask(msk[2]),
        .ram_address_out(addr2), .ram_wdata(wd2),
        .ram_read_strobe(rdS[2]), .ram_write_strobe(wrS[2]),
        .address_strobe(aStb[2]), .header_error(hErr[2]),
        .byte_count(cnt2)
    );

    // Free-running clock, 10 time units per period.
    initial SPI_CLK = 1'b0;
    always #5 SPI_CLK = ~SPI_CLK;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int getAddr(int id);
        case (id)
            0:       return int'(addr0);
            1:       return int'(addr1);
            default: return int'(addr2);
        endcase
    endfunction

    function automatic int getWd(int id);
        case (id)
            0:       return int'(wd0);
            1:       return int'(wd1);
            default: return int'(wd2);
        endcase
    endfunction

    function automatic int getCnt(int id);
        case (id)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Reference address step: wrap inside a block of 2^WRAP_W (or the whole
    // address space when linear), keeping the block base.
    function automatic int modelNext(int id, int a);
        int span;
        int base;
        span = (ww[id] == 0) ? (1 << aw[id]) : (1 << ww[id]);
        base = a - (a % span);
        return base + ((a % span) + 1) % span;
    endfunction

    task automatic pushExp(int id, int kind, int addr, int data);
        expEvent_t e;
        e.id   = id;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        expq.push_back(e);
    endtask

    task automatic checkOutput(string name, int actual, int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkEvent(int id, int kind, int addr, int data);
        expEvent_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected %s on dut%0d: got addr=0x%0h data=0x%0h, required no event",
                     kindName[kind], id, addr, data);
        end else begin
            e = expq.pop_front();
            if (e.id != id || e.kind != kind || e.addr != addr || (kind == 2 && e.data != data)) begin
                bad++;
                $display("[TB] FAIL event: got dut%0d %s addr=0x%0h data=0x%0h, required dut%0d %s addr=0x%0h data=0x%0h",
                         id, kindName[kind], addr, data, e.id, kindName[e.kind], e.addr, e.data);
            end
        end
    endtask

    // Monitor: every strobe any instance presents is matched against the
    // head of the expected-event queue; read/write overlap is also flagged.
    always @(negedge SPI_CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (aStb[i] === 1'b1) checkEvent(i, 0, getAddr(i), 0);
            if (rdS[i] === 1'b1)  checkEvent(i, 1, getAddr(i), 0);
            if (wrS[i] === 1'b1)  checkEvent(i, 2, getAddr(i), getWd(i));
            if (hErr[i] === 1'b1) checkEvent(i, 3, 0, 0);
            if (rdS[i] === 1'b1 && wrS[i] === 1'b1) begin
                bad++;
                $display("[TB] FAIL strobe_overlap dut%0d: got read=1 write=1, required at most one", i);
            end
        end
    end

    // Drive one cycle of inputs on instance d, then drop the pulses.
    task automatic applyStimulus(int d, bit s, bit e, bit r, bit q, bit m, logic [7:0] b);
        sot[d] = s;
        eot[d] = e;
        dir[d] = r;
        dor[d] = q;
        msk[d] = m;
        din[d] = b;
        @(posedge SPI_CLK);
        #1;
        sot[d] = 1'b0;
        eot[d] = 1'b0;
        dir[d] = 1'b0;
        dor[d] = 1'b0;
        msk[d] = 1'b0;
    endtask

    task automatic idle(int k);
        repeat (k) applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic sendHeader(int d, int hdrVal);
        applyStimulus(d, 1, 0, 0, 0, 0, 8'h00);
        for (int i = abytes[d] - 1; i >= 0; i--) begin
            applyStimulus(d, 0, 0, 1, 0, 0, 8'((hdrVal >> (8 * i)) & 255));
        end
    endtask

    // Write frame using dataQ/maskQ as payload.
    task automatic writeFrame(int d, int hdrVal, int gapMax, bit eotWithLast);
        int a;
        int n;
        int expCnt;
        n = dataQ.size();
        a = hdrVal % (1 << aw[d]);
        pushExp(d, 0, a, 0);
        sendHeader(d, hdrVal);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(gapMax, 0));
            if (maskQ[i]) pushExp(d, 2, a, int'(dataQ[i]));
            a = modelNext(d, a);
            applyStimulus(d, 0, eotWithLast && (i == n - 1), 1, 0, maskQ[i], dataQ[i]);
        end
        if (!eotWithLast) begin
            idle($urandom_range(2, 0));
            applyStimulus(d, 0, 1, 0, 0, 0, 8'h00);
        end
        idle(2);
        expCnt = (n < cntMax[d]) ? n : cntMax[d];
        checkOutput("byte_count_wr", getCnt(d), expCnt);
    endtask

    // Read frame: prefetch at the header address, then one read per request.
    task automatic readFrame(int d, int hdrVal, int nReq, int gapMax);
        int a;
        int expCnt;
        a = hdrVal % (1 << aw[d]);
        pushExp(d, 0, a, 0);
        pushExp(d, 1, a, 0);
        sendHeader(d, hdrVal);
        idle(1);
        for (int i = 0; i < nReq; i++) begin
            idle($urandom_range(gapMax, 0));
            a = modelNext(d, a);
            pushExp(d, 1, a, 0);
            applyStimulus(d, 0, 0, 0, 1, 0, 8'h00);
        end
        idle(1 + $urandom_range(1, 0));
        applyStimulus(d, 0, 1, 0, 0, 0, 8'h00);
        idle(2);
        expCnt = (nReq < cntMax[d]) ? nReq : cntMax[d];
        checkOutput("byte_count_rd", getCnt(d), expCnt);
    endtask

    task automatic loadData(int n, bit randomMask);
        dataQ.delete();
        maskQ.delete();
        for (int i = 0; i < n; i++) begin
            dataQ.push_back(8'($urandom_range(255, 0)));
            maskQ.push_back(randomMask ? bit'($urandom_range(1, 0)) : 1'b1);
        end
    endtask

    initial begin
        int hdr;
        total = 0;
        bad   = 0;
        sot = '0; eot = '0; dir = '0; dor = '0; msk = '0;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        RST = 1'b1;
        repeat (3) @(posedge SPI_CLK);
        #1;
        RST = 1'b0;

        // Reset state of every instance.
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_addr", getAddr(i), 0);
            checkOutput("reset_wdata", getWd(i), 0);
            checkOutput("reset_count", getCnt(i), 0);
            checkOutput("reset_strobes", int'({rdS[i], wrS[i], aStb[i], hErr[i]}), 0);
        end

        // Basic write frame 0x1234 <- AA, BB.
        dataQ.delete(); maskQ.delete();
        dataQ.push_back(8'hAA); maskQ.push_back(1'b1);
        dataQ.push_back(8'hBB); maskQ.push_back(1'b1);
        writeFrame(0, 16'h1234, 0, 0);

        // Basic read frame 0x0010 with three requests.
        readFrame(0, 16'h8010, 3, 0);

        // Wrapped burst at 0x0006 and counter saturation on the 3-bit counter.
        loadData(4, 0);
        writeFrame(1, 16'h0006, 1, 0);
        loadData(10, 0);
        writeFrame(1, 16'h0005, 0, 0);

        // Linear roll-over at the top of the address space.
        loadData(2, 0);
        writeFrame(0, 16'h7FFF, 0, 0);

        // Frame ending mid-header, then a stray byte while idle.
        pushExp(0, 3, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 0, 8'h12);
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h00);
        idle(2);
        applyStimulus(0, 0, 0, 1, 0, 1, 8'h99);
        idle(2);

        // End of transfer coincident with the last data byte.
        loadData(3, 0);
        writeFrame(0, 16'h0200, 0, 1);

        // Reset in the middle of a write burst.
        pushExp(0, 0, 16'h0100, 0);
        sendHeader(0, 16'h0100);
        pushExp(0, 2, 16'h0100, 8'h11);
        applyStimulus(0, 0, 0, 1, 0, 1, 8'h11);
        pushExp(0, 2, 16'h0101, 8'h22);
        applyStimulus(0, 0, 0, 1, 0, 1, 8'h22);
        RST = 1'b1;
        @(posedge SPI_CLK);
        #1;
        RST = 1'b0;
        checkOutput("midreset_addr", getAddr(0), 0);
        checkOutput("midreset_wdata", getWd(0), 0);
        checkOutput("midreset_count", getCnt(0), 0);
        loadData(2, 0);
        writeFrame(0, 16'h0345, 0, 0);

        // Restart mid-read, with a coincident request that must be dropped.
        pushExp(0, 0, 16'h0020, 0);
        pushExp(0, 1, 16'h0020, 0);
        sendHeader(0, 16'h8020);
        idle(1);
        pushExp(0, 1, 16'h0021, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h00);
        idle(1);
        applyStimulus(0, 1, 0, 0, 1, 0, 8'h00);
        checkOutput("restart_count", getCnt(0), 0);
        pushExp(0, 0, 16'h0040, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 0, 8'h40);
        pushExp(0, 2, 16'h0040, 8'h5A);
        applyStimulus(0, 0, 0, 1, 0, 1, 8'h5A);
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h00);
        idle(2);
        checkOutput("restart_wr_count", getCnt(0), 1);

        // Three-byte header read.
        readFrame(2, 24'h812345, 1, 0);

        // Randomized frames on the default instance.
        for (int f = 0; f < 30; f++) begin
            hdr = int'($urandom_range(16'hFFFF, 0));
            if (hdr >= 16'h8000) begin
                readFrame(0, hdr, $urandom_range(5, 0), 2);
            end else begin
                loadData($urandom_range(6, 1), 1);
                writeFrame(0, hdr, 2, bit'($urandom_range(1, 0)));
            end
        end

        idle(5);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL missing_events: got %0d still pending, required 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
